// File: rtl/datapath_ctrl.sv
// Multicycle control sequencer for the shared-bus RV32 datapath: fetch, decode, strobe sequencing, PC and retire count.
// Optional feature: define DPCTRL_BRANCH_EN to support BEQ/BNE; otherwise opcode 1100011 traps as illegal.
module datapath_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      ir,
  input  logic             zero,
  input  logic             busy,
  output logic [3:0]       ALUControl,
  output logic             lda,
  output logic             ldb,
  output logic             ldma,
  output logic             ldiR,
  output logic [1:0]       reg_sel,
  output logic             reg_en,
  output logic             mem_en,
  output logic             alu_en,
  output logic             IMM_en,
  output logic             reg_we,
  output logic             mem_we,
  output logic [1:0]       ExtendSign_sel,
  output logic             pc_oe,
  output logic [31:0]      pc,
  output logic [CNT_W-1:0] retired,
  output logic             illegal
);

  localparam logic [2:0] F0 = 3'd0, F1 = 3'd1, D0 = 3'd2, D1 = 3'd3,
                         EX = 3'd4, MEM = 3'd5, WB_PC = 3'd6, TRAP = 3'd7;

  localparam logic [3:0] ALU_AND = 4'b0000, ALU_OR  = 4'b0001, ALU_ADD = 4'b0010,
                         ALU_XOR = 4'b0011, ALU_SUB = 4'b0110, ALU_SLT = 4'b0111;

  logic [2:0] state;
  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       is_r, is_i, is_lw, is_sw, is_br, legal;
  logic [3:0] alu_op;

  assign opcode = ir[6:0];
  assign f3     = ir[14:12];
  assign f7     = ir[31:25];

`ifdef DPCTRL_BRANCH_EN
  logic        br_taken;
  logic [31:0] br_off;
  logic        unused_ir;
  assign br_off    = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign unused_ir = ^ir[24:15];
`else
  logic unused_in;
  assign unused_in = ^{ir[24:15], ir[11:7], zero};
`endif

  // Class flags already include funct3/funct7 legality, so later states trust them.
  always_comb begin
    is_r   = 1'b0;
    is_i   = 1'b0;
    is_lw  = 1'b0;
    is_sw  = 1'b0;
    is_br  = 1'b0;
    alu_op = ALU_ADD;
    case (opcode)
      7'b0110011: begin
        is_r = 1'b1;
        case ({f7, f3})
          {7'b0000000, 3'b000}: alu_op = ALU_ADD;
          {7'b0100000, 3'b000}: alu_op = ALU_SUB;
          {7'b0000000, 3'b111}: alu_op = ALU_AND;
          {7'b0000000, 3'b110}: alu_op = ALU_OR;
          {7'b0000000, 3'b100}: alu_op = ALU_XOR;
          {7'b0000000, 3'b010}: alu_op = ALU_SLT;
          default:              is_r   = 1'b0;
        endcase
      end
      7'b0010011: begin
        is_i = 1'b1;
        case (f3)
          3'b000:  alu_op = ALU_ADD;
          3'b010:  alu_op = ALU_SLT;
          3'b100:  alu_op = ALU_XOR;
          3'b110:  alu_op = ALU_OR;
          3'b111:  alu_op = ALU_AND;
          default: is_i   = 1'b0;
        endcase
      end
      7'b0000011: is_lw = (f3 == 3'b010);
      7'b0100011: is_sw = (f3 == 3'b010);
`ifdef DPCTRL_BRANCH_EN
      7'b1100011: is_br = (f3 == 3'b000) || (f3 == 3'b001);
`endif
      default: ;
    endcase
  end

  assign legal = is_r | is_i | is_lw | is_sw | is_br;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= F0;
      pc       <= RESET_PC;
      retired  <= '0;
      illegal  <= 1'b0;
`ifdef DPCTRL_BRANCH_EN
      br_taken <= 1'b0;
`endif
    end else begin
      case (state)
        F0:    state <= F1;
        F1:    if (!busy) state <= D0;
        D0: begin
          if (legal) begin
            state <= D1;
          end else begin
            illegal <= 1'b1;
            state   <= TRAP;
          end
        end
        D1:    state <= EX;
        EX: begin
          state <= (is_lw | is_sw) ? MEM : WB_PC;
`ifdef DPCTRL_BRANCH_EN
          // funct3[0] distinguishes BNE from BEQ
          br_taken <= is_br & (ir[12] ? ~zero : zero);
`endif
        end
        MEM:   if (!busy) state <= WB_PC;
        WB_PC: begin
`ifdef DPCTRL_BRANCH_EN
          pc <= br_taken ? pc + br_off : pc + 32'd4;
`else
          pc <= pc + 32'd4;
`endif
          retired <= retired + CNT_W'(1);
          state   <= F0;
        end
        TRAP:    state <= TRAP;
        default: state <= TRAP;
      endcase
    end
  end

  // Outputs are forced to their idle values while reset is held, independent of the clock.
  always_comb begin
    ALUControl     = ALU_ADD;
    lda            = 1'b0;
    ldb            = 1'b0;
    ldma           = 1'b0;
    ldiR           = 1'b0;
    reg_sel        = 2'b00;
    reg_en         = 1'b0;
    mem_en         = 1'b0;
    alu_en         = 1'b0;
    IMM_en         = 1'b0;
    reg_we         = 1'b0;
    mem_we         = 1'b0;
    ExtendSign_sel = 2'b00;
    pc_oe          = 1'b0;
    if (rst) begin
      case (state)
        F0: begin
          pc_oe = 1'b1;
          ldma  = 1'b1;
        end
        F1: begin
          mem_en = 1'b1;
          ldiR   = 1'b1;
        end
        D0: begin
          if (legal) begin
            reg_en = 1'b1;
            lda    = 1'b1;
          end
        end
        D1: begin
          ldb = 1'b1;
          if (is_r | is_br) begin
            reg_sel = 2'b01;
            reg_en  = 1'b1;
          end else if (is_sw) begin
            IMM_en         = 1'b1;
            ExtendSign_sel = 2'b01;
          end else begin
            IMM_en = 1'b1;
          end
        end
        EX: begin
          alu_en = 1'b1;
          if (is_r | is_i) begin
            ALUControl = alu_op;
            reg_sel    = 2'b10;
            reg_we     = 1'b1;
          end else if (is_lw | is_sw) begin
            ldma = 1'b1;
          end else if (is_br) begin
            ALUControl = ALU_SUB;
          end
        end
        MEM: begin
          if (is_lw) begin
            mem_en  = 1'b1;
            reg_sel = 2'b10;
            reg_we  = 1'b1;
          end else if (is_sw) begin
            reg_sel = 2'b01;
            reg_en  = 1'b1;
            mem_we  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/datapath_ctrl.md
# datapath_ctrl

Multicycle control sequencer for the shared-bus RV32 datapath. It sits directly upstream of `datapath`. It fetches and decodes each instruction from the datapath's instruction register, then drives every datapath load, drive and write strobe one state at a time. It owns the program counter, computes branch targets and exposes a retired-instruction counter.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value after reset.
- `CNT_W`, 16, width of the retired-instruction counter.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `ir`  in  32  datapath `ir_out`.
- `zero`  in  1  datapath ALU zero flag.
- `busy`  in  1  datapath memory busy.
- `ALUControl`  out  4  ALU operation: AND 0000, OR 0001, ADD 0010, XOR 0011, SUB 0110, SLT 0111.
- `lda`, `ldb`, `ldma`, `ldiR`  out  1 each  A, B, MA and IR load strobes.
- `reg_sel`  out  2  register-file port select: 00 rs1, 01 rs2, 10 rd.
- `reg_en`, `mem_en`, `alu_en`, `IMM_en`  out  1 each  bus drive enables.
- `reg_we`, `mem_we`  out  1 each  write enables; both write from the bus.
- `ExtendSign_sel`  out  2  immediate format: 00 I, 01 S, 10 B.
- `pc_oe`  out  1  drives `pc` onto the bus.
- `pc`  out  32  current PC.
- `retired`  out  CNT_W  instructions retired, wraps.
- `illegal`  out  1  sticky unsupported-opcode flag.

## Operation
States: F0, F1, D0, D1, EX, MEM, WB_PC, TRAP.

- **F0:** `pc_oe`=1, `ldma`=1.
- **F1:** `mem_en`=1, `ldiR`=1.
  - Held while `busy`=1.
  - Exits on the first edge where `busy`=0.
- **D0:** decode `ir[6:0]`.
  - Supported opcodes: 0110011 (R), 0010011 (I-ALU), 0000011 (LW), 0100011 (SW), 1100011 (BEQ/BNE).
  - Supported opcode: `reg_sel`=00, `reg_en`=1, `lda`=1; next state D1.
  - Anything else, or an unsupported funct3/funct7: set `illegal`, go to TRAP.
- **D1:** loads B.
  - R and branch: `reg_sel`=01, `reg_en`=1, `ldb`=1.
  - I-ALU and LW: `IMM_en`=1, `ExtendSign_sel`=00, `ldb`=1.
  - SW: `IMM_en`=1, `ExtendSign_sel`=01, `ldb`=1.
- **EX:** `alu_en`=1 in every case.
  - R and I-ALU: `ALUControl` from funct3/funct7; `reg_sel`=10, `reg_we`=1; next WB_PC.
  - LW and SW: ADD, `ldma`=1; next MEM.
  - Branch: SUB; `zero` sampled this cycle; next WB_PC.
- **MEM:** held while `busy`=1.
  - LW: `mem_en`=1, `reg_sel`=10, `reg_we`=1.
  - SW: `reg_sel`=01, `reg_en`=1, `mem_we`=1.
- **WB_PC:** updates PC, increments `retired`; next F0.
  - Branch taken (BEQ and `zero`=1, or BNE and `zero`=0): `pc` <= `pc` + sext({ir[31],ir[7],ir[30:25],ir[11:8],1'b0}).
  - Otherwise `pc` <= `pc`+4.
  - All PC arithmetic is 32-bit modulo.
- **TRAP:** all strobes 0; held until reset.

General rules:
- Outputs are Moore, decoded from the state register and the current `ir`.
- At most one of `reg_en`, `mem_en`, `alu_en`, `IMM_en`, `pc_oe` is 1 in any state.
- `reg_we` and `mem_we` are never both 1.
- `retired` wraps from all-ones to 0.
- `x0` writes are issued anyway; the register file discards them.

## Timing
- **Reset:** `rst`=0 forces, asynchronously:
  - state F0, `pc`=`RESET_PC`, `retired`=0, `illegal`=0;
  - all strobes and enables 0, `ALUControl`=0010, `reg_sel`=00, `ExtendSign_sel`=00.
  - Release takes effect at the first rising edge after `rst`=1.
  - Reset mid-instruction abandons it without retiring.
- **Latency** with `busy`=0: R/I-ALU and branch take 6 cycles, LW/SW take 7 cycles (F0 to WB_PC inclusive).
- **Busy stalls:** each cycle of `busy`=1 in F1 or MEM adds one cycle. Strobes stay asserted throughout the stall.
- **Timing of effects:**
  - `pc` changes one edge after WB_PC.
  - `illegal` rises one edge after D0.

## Configuration
- `DPCTRL_BRANCH_EN` defined:
  - opcode 1100011 with funct3 000 (BEQ) or 001 (BNE) is supported;
  - other funct3 values are illegal.
- Undefined:
  - 1100011 is illegal;
  - the branch-target adder and the `zero` sampling are not compiled.

## Test plan
- **Reset:** reset low mid-EX → all outputs at reset values immediately; after release, `pc`=0 and the first state is F0.
- **ADDI x1,x0,5** (0x00500093), `busy`=0 → 6 cycles; EX asserts `alu_en`=1, `reg_we`=1, `reg_sel`=10, `ALUControl`=0010; then `pc`=4, `retired`=1.
- **LW with stall:** `busy`=1 for 3 cycles in MEM → MEM lasts 4 cycles with `mem_en`/`reg_we` held; instruction completes in 10 cycles.
- **BEQ x0,x0,-8** at `pc`=0x10, `zero`=1 → `pc`=0x08. Repeat with `zero`=0 → `pc`=0x14. Without the macro → `illegal`=1, TRAP.
- **Illegal opcode** 0x0000007F → `illegal`=1 after D0; strobes stay 0 for 20 cycles; `retired` unchanged.
- **Bus exclusivity:** random instruction mix, `CNT_W`=4 → bus-enable one-hot-or-zero every cycle; `retired` wraps 15→0.
